mos6502s_operand_fetch: RTL and testbench

- Sequencer directly upstream of the effective-address stage.
- After opcode decode, it reads the instruction's operand bytes from the CPU memory port.
- For the three indirect modes it also reads the two pointer bytes.
- It presents operand_lo/hi and indirect_lo/hi, registered and stable, to the address stage, then pulses done.

---
 rtl/mos6502s_pkg.sv | 51 +++++
 rtl/mos6502s_fetch_addr_mux.sv | 47 ++++
 rtl/mos6502s_operand_fetch.sv | 150 +++++++++++++++
 tb/tb_mos6502s_operand_fetch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mos6502s_pkg.sv
// rtl/mos6502s_pkg.sv - shared addressing-mode constants, fetch FSM states and operand-count helper
// Shared by the operand-fetch sequencer and the effective-address stage.
// Holds the 4-bit mode encoding, the fetch FSM state enum, and helpers
// that map a mode to its operand byte count.
package mos6502s_pkg;

  localparam logic [3:0] MODE_IMPLIED = 4'd0;
  localparam logic [3:0] MODE_ACCUM   = 4'd1;
  localparam logic [3:0] MODE_IMM     = 4'd2;
  localparam logic [3:0] MODE_ZP      = 4'd3;
  localparam logic [3:0] MODE_ZPX     = 4'd4;
  localparam logic [3:0] MODE_ZPY     = 4'd5;
  localparam logic [3:0] MODE_ABS     = 4'd6;
  localparam logic [3:0] MODE_ABSX    = 4'd7;
  localparam logic [3:0] MODE_ABSY    = 4'd8;
  localparam logic [3:0] MODE_IND     = 4'd9;
  localparam logic [3:0] MODE_INDX    = 4'd10;
  localparam logic [3:0] MODE_INDY    = 4'd11;
  localparam logic [3:0] MODE_REL     = 4'd12;
  localparam logic [3:0] MODE_STACK   = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP_LO  = 3'd1,
    ST_OP_HI  = 3'd2,
    ST_PTR_LO = 3'd3,
    ST_PTR_HI = 3'd4,
    ST_DONE   = 3'd5
  } fetch_state_t;

  // Encodings 14 and 15 are unused and behave as implied.
  function automatic logic [3:0] normalize_mode(input logic [3:0] mode);
    logic [3:0] m;
    m = (mode > MODE_STACK) ? MODE_IMPLIED : mode;
    return m;
  endfunction

  // Number of operand bytes following the opcode (0, 1 or 2).
  function automatic logic [1:0] operand_count(input logic [3:0] mode);
    logic [1:0] n;
    n = 2'd0;
    case (mode)
      MODE_IMM, MODE_ZP, MODE_ZPX, MODE_ZPY,
      MODE_INDX, MODE_INDY, MODE_REL:           n = 2'd1;
      MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND: n = 2'd2;
      default:                                  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mos6502s_fetch_addr_mux.sv
// rtl/mos6502s_fetch_addr_mux.sv - read-address select for the operand-fetch sequencer
// Purely combinational. Picks the memory read address from the current
// fetch state and latched values, applying the 6502 wrap rules.
// Ports:
//   state       current fetch FSM state
//   mode        latched (normalized) addressing mode
//   pc          latched address of the first operand byte
//   operand_lo  captured first operand byte
//   operand_hi  captured second operand byte
//   x           latched X index
//   mem_addr    selected read address (0 outside read states)
module mos6502s_fetch_addr_mux
  import mos6502s_pkg::*;
(
  input  fetch_state_t state,
  input  logic [3:0]   mode,
  input  logic [15:0]  pc,
  input  logic [7:0]   operand_lo,
  input  logic [7:0]   operand_hi,
  input  logic [7:0]   x,
  output logic [15:0]  mem_addr
);

  logic [7:0] zp_ptr;

  always_comb begin
    // Zero-page pointer: (zp,X) adds X with 8-bit wrap, (zp),Y uses the operand as-is.
    zp_ptr   = (mode == MODE_INDX) ? operand_lo + x : operand_lo;
    mem_addr = 16'h0000;
    case (state)
      ST_OP_LO: mem_addr = pc;
      ST_OP_HI: mem_addr = pc + 16'd1;
      ST_PTR_LO: begin
        if (mode == MODE_IND) mem_addr = {operand_hi, operand_lo};
        else                  mem_addr = {8'h00, zp_ptr};
      end
      ST_PTR_HI: begin
        // High pointer byte never carries into the page byte: the (abs)
        // form keeps the NMOS page-wrap bug, the zero-page forms stay in page 0.
        if (mode == MODE_IND) mem_addr = {operand_hi, operand_lo + 8'd1};
        else                  mem_addr = {8'h00, zp_ptr + 8'd1};
      end
      default: mem_addr = 16'h0000;
    endcase
  end

endmodule

// File: rtl/mos6502s_operand_fetch.sv
// rtl/mos6502s_operand_fetch.sv - operand and indirect-pointer fetch sequencer ahead of the address stage
// Reads the operand bytes of a decoded instruction, plus the two pointer
// bytes for the indirect modes, then pulses done with stable outputs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         begin a fetch for the given addressing mode (IDLE only)
//   pc_in, x_reg        first operand address, X index
//   mem_addr, mem_rd    read request to the CPU memory port
//   mem_rdata, mem_ready read data and completion
//   operand_lo/hi       captured operand bytes
//   indirect_lo/hi      captured pointer bytes
//   pc_next             pc_in + operand count
//   busy, done          activity flag, one-cycle completion pulse
//   bus_error           qualifies done when a read timed out
module mos6502s_operand_fetch
  import mos6502s_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mode,
  input  logic [15:0] pc_in,
  input  logic [7:0]  x_reg,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  operand_lo,
  output logic [7:0]  operand_hi,
  output logic [7:0]  indirect_lo,
  output logic [7:0]  indirect_hi,
  output logic [15:0] pc_next,
  output logic        busy,
  output logic        done,
  output logic        bus_error
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
  localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

  fetch_state_t state_q, state_d;
  logic [3:0]   mode_q;
  logic [15:0]  pc_q;
  logic [7:0]   x_q;
  logic [7:0]   wait_q;
  logic         err_q;
  logic         rd_state;
  logic         timeout_hit;
  logic [8:0]   wait_inc;

  assign rd_state  = (state_q == ST_OP_LO) || (state_q == ST_OP_HI) ||
                     (state_q == ST_PTR_LO) || (state_q == ST_PTR_HI);
  assign wait_inc  = {1'b0, wait_q} + 9'd1;
  // A completing read always wins over the timeout on the same cycle.
  assign timeout_hit = TIMEOUT_EN && rd_state && !mem_ready && (wait_inc == TIMEOUT_LIM);

  assign mem_rd    = rd_state;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign bus_error = done && err_q;

  mos6502s_fetch_addr_mux u_addr_mux (
    .state      (state_q),
    .mode       (mode_q),
    .pc         (pc_q),
    .operand_lo (operand_lo),
    .operand_hi (operand_hi),
    .x          (x_q),
    .mem_addr   (mem_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (operand_count(mode) == 2'd0) ? ST_DONE : ST_OP_LO;
      end
      ST_OP_LO: begin
        if (mem_ready) begin
          if (operand_count(mode_q) == 2'd2)                         state_d = ST_OP_HI;
          else if (mode_q == MODE_INDX || mode_q == MODE_INDY)       state_d = ST_PTR_LO;
          else                                                       state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_OP_HI: begin
        if (mem_ready)        state_d = (mode_q == MODE_IND) ? ST_PTR_LO : ST_DONE;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_PTR_LO: begin
        if (mem_ready)        state_d = ST_PTR_HI;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_PTR_HI: begin
        if (mem_ready || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 4'd0;
      pc_q        <= 16'h0000;
      x_q         <= 8'h00;
      wait_q      <= 8'h00;
      err_q       <= 1'b0;
      operand_lo  <= 8'h00;
      operand_hi  <= 8'h00;
      indirect_lo <= 8'h00;
      indirect_hi <= 8'h00;
      pc_next     <= 16'h0000;
    end else begin
      if (state_q == ST_IDLE && start) begin
        mode_q      <= normalize_mode(mode);
        pc_q        <= pc_in;
        x_q         <= x_reg;
        pc_next     <= pc_in + {14'd0, operand_count(mode)};
        operand_hi  <= 8'h00;
        indirect_lo <= 8'h00;
        indirect_hi <= 8'h00;
        err_q       <= 1'b0;
      end
      if (rd_state && mem_ready) begin
        case (state_q)
          ST_OP_LO:  operand_lo  <= mem_rdata;
          ST_OP_HI:  operand_hi  <= mem_rdata;
          ST_PTR_LO: indirect_lo <= mem_rdata;
          ST_PTR_HI: indirect_hi <= mem_rdata;
          default:   ;
        endcase
      end
      if (timeout_hit) err_q <= 1'b1;
      // Counter only runs while a read is stalled, so it is zero on entry to every read state.
      if (rd_state && !mem_ready) wait_q <= wait_q + 8'd1;
      else                        wait_q <= 8'h00;
    end
  end

endmodule

// File: tb/tb_mos6502s_operand_fetch.sv
// tb/tb_mos6502s_operand_fetch.sv - self-checking bench for the operand-fetch sequencer
module tb_mos6502s_operand_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  x_reg = 8'h00;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic [7:0]  operand_lo, operand_hi, indirect_lo, indirect_hi;
  logic [15:0] pc_next;
  logic        busy, done, bus_error;

  always #5 clk = ~clk;

  mos6502s_operand_fetch #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pc_in(pc_in), .x_reg(x_reg),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .operand_lo(operand_lo), .operand_hi(operand_hi), .indirect_lo(indirect_lo),
    .indirect_hi(indirect_hi), .pc_next(pc_next), .busy(busy), .done(done), .bus_error(bus_error)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem [0:65535];

  // Expected results of one fetch
  int          e_n, e_done;
  logic [15:0] e_addr [8];
  logic [7:0]  e_lo, e_hi, e_ilo, e_ihi;
  logic [15:0] e_pcn;
  bit          e_berr;

  // Observed results of one fetch
  int          a_n, a_done;
  logic [15:0] a_addr [8];
  bit          a_berr;

  // Reference-model architectural registers
  logic [7:0] mdl_lo = 8'h00, mdl_hi = 8'h00, mdl_ilo = 8'h00, mdl_ihi = 8'h00;

  typedef struct {
    logic [3:0]  mode;
    logic [15:0] pc;
    logic [7:0]  x;
    int          waits;
    int          stuck;
    bit          poke;
    int          npre;
    logic [15:0] pa [6];
    logic [7:0]  pd [6];
    int          nrd;
    logic [15:0] ea [4];
    logic [7:0]  lo, hi, ilo, ihi;
    logic [15:0] pcn;
    int          dcyc;
    bit          berr;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic vdef(input int i, input logic [3:0] m, input logic [15:0] pc, input logic [7:0] x,
                      input int w, input int st, input bit pk,
                      input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] ilo, input logic [7:0] ihi,
                      input logic [15:0] pcn, input int dc, input bit be);
    vt[i].mode = m; vt[i].pc = pc; vt[i].x = x; vt[i].waits = w; vt[i].stuck = st; vt[i].poke = pk;
    vt[i].lo = lo; vt[i].hi = hi; vt[i].ilo = ilo; vt[i].ihi = ihi;
    vt[i].pcn = pcn; vt[i].dcyc = dc; vt[i].berr = be; vt[i].npre = 0; vt[i].nrd = 0;
  endtask

  task automatic vpre(input int i, input logic [15:0] a, input logic [7:0] d);
    vt[i].pa[vt[i].npre] = a;
    vt[i].pd[vt[i].npre] = d;
    vt[i].npre++;
  endtask

  task automatic vrd(input int i, input logic [15:0] a);
    vt[i].ea[vt[i].nrd] = a;
    vt[i].nrd++;
  endtask

  // Reference model: walks the list of reads the instruction needs, using
  // plain address arithmetic, and stops at a read that never completes.
  task automatic model(input logic [3:0] m_in, input logic [15:0] pc, input logic [7:0] x,
                       input int waits, input int stuck);
    int cnt, total, slot;
    logic [3:0] m;
    logic [15:0] a;
    logic [7:0] zp;
    m = (m_in > 4'd13) ? 4'd0 : m_in;
    if ((m >= 2 && m <= 5) || (m >= 10 && m <= 12)) cnt = 1;
    else if (m >= 6 && m <= 9) cnt = 2;
    else cnt = 0;
    total = cnt + ((m >= 9 && m <= 11) ? 2 : 0);
    e_pcn = pc + 16'(cnt);
    mdl_hi = 8'h00; mdl_ilo = 8'h00; mdl_ihi = 8'h00;
    e_berr = 1'b0; e_n = 0;
    for (int i = 0; i < total; i++) begin
      if (i < cnt) a = pc + 16'(i);
      else if (m == 9) a = {mdl_hi, mdl_lo + 8'(i - cnt)};
      else begin
        zp = mdl_lo + ((m == 10) ? x : 8'd0) + 8'(i - cnt);
        a = {8'h00, zp};
      end
      if (i == stuck) begin
        e_berr = 1'b1;
        break;
      end
      slot = (i < cnt) ? i : 2 + i - cnt;
      case (slot)
        0: mdl_lo  = mem[a];
        1: mdl_hi  = mem[a];
        2: mdl_ilo = mem[a];
        default: mdl_ihi = mem[a];
      endcase
      e_addr[e_n] = a;
      e_n++;
    end
    e_done = 1 + e_n * (1 + waits) + (e_berr ? TO : 0);
    e_lo = mdl_lo; e_hi = mdl_hi; e_ilo = mdl_ilo; e_ihi = mdl_ihi;
  endtask

  // Issues start, then acts as the memory: each read waits 'waits' cycles,
  // read number 'stuck' never completes. Returns in the done cycle.
  task automatic run_fetch(input logic [3:0] m, input logic [15:0] pc, input logic [7:0] x,
                           input int waits, input int stuck, input bit poke, input string tag);
    int wl, rd_idx;
    bit in_wait, got_done;
    logic [15:0] last_addr;
    a_n = 0; a_done = -1; a_berr = 1'b0;
    wl = 0; rd_idx = 0; in_wait = 1'b0; got_done = 1'b0; last_addr = 16'h0000;
    start = 1'b1; mode = m; pc_in = pc; x_reg = x; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
      start = (poke && cyc == 2);
      if (poke && cyc == 2) begin mode = 4'd6; pc_in = 16'hFFFF; end
      if (mem_rd) begin
        if (in_wait) check({tag, " addr_stable"}, mem_addr, last_addr);
        else wl = waits;
        if (rd_idx != stuck && wl == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          if (a_n < 8) a_addr[a_n] = mem_addr;
          a_n++; rd_idx++; in_wait = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 8'($urandom);
          wl--; in_wait = 1'b1; last_addr = mem_addr;
        end
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = 8'($urandom);
        in_wait = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        a_done = cyc;
        a_berr = bus_error;
        check({tag, " busy_at_done"}, busy, 1'b1);
      end else begin
        if (bus_error) check({tag, " berr_without_done"}, bus_error, 1'b0);
        @(posedge clk); #1;
      end
    end
    if (!got_done) begin
      n_chk++; n_fail++;
      $display("FAIL %s done_timeout: no done within 200 cycles", tag);
    end
    start = 1'b0;
  endtask

  task automatic compare(input string tag);
    check({tag, " nreads"}, a_n, e_n);
    for (int i = 0; i < e_n; i++)
      if (i < a_n) check($sformatf("%s read%0d_addr", tag, i), a_addr[i], e_addr[i]);
    check({tag, " operand_lo"}, operand_lo, e_lo);
    check({tag, " operand_hi"}, operand_hi, e_hi);
    check({tag, " indirect_lo"}, indirect_lo, e_ilo);
    check({tag, " indirect_hi"}, indirect_hi, e_ihi);
    check({tag, " pc_next"}, pc_next, e_pcn);
    check({tag, " done_cycle"}, a_done, e_done);
    check({tag, " bus_error"}, a_berr, e_berr);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " idle_after"}, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_addr"}, mem_addr, 16'h0);
    check({tag, " mem_rd"}, mem_rd, 1'b0);
    check({tag, " operand_lo"}, operand_lo, 8'h0);
    check({tag, " operand_hi"}, operand_hi, 8'h0);
    check({tag, " indirect_lo"}, indirect_lo, 8'h0);
    check({tag, " indirect_hi"}, indirect_hi, 8'h0);
    check({tag, " pc_next"}, pc_next, 16'h0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " bus_error"}, bus_error, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] rm;
    int rw, rs;
    string tag;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    //   idx mode  pc        x      w  stuck poke lo     hi     ilo    ihi    pc_next  dcyc berr
    vdef(0,  6,  16'h0300, 8'h00, 0, -1, 0, 8'h34, 8'h12, 8'h00, 8'h00, 16'h0302, 3, 0);
    vpre(0, 16'h0300, 8'h34); vpre(0, 16'h0301, 8'h12);
    vrd(0, 16'h0300); vrd(0, 16'h0301);
    vdef(1,  9,  16'h0400, 8'h00, 0, -1, 0, 8'hFF, 8'h12, 8'h00, 8'h80, 16'h0402, 5, 0);
    vpre(1, 16'h0400, 8'hFF); vpre(1, 16'h0401, 8'h12); vpre(1, 16'h12FF, 8'h00);
    vpre(1, 16'h1200, 8'h80); vpre(1, 16'h1300, 8'h55);
    vrd(1, 16'h0400); vrd(1, 16'h0401); vrd(1, 16'h12FF); vrd(1, 16'h1200);
    vdef(2, 10,  16'h0500, 8'h03, 0, -1, 0, 8'hFE, 8'h00, 8'hCD, 8'hAB, 16'h0501, 4, 0);
    vpre(2, 16'h0500, 8'hFE); vpre(2, 16'h0001, 8'hCD); vpre(2, 16'h0002, 8'hAB);
    vrd(2, 16'h0500); vrd(2, 16'h0001); vrd(2, 16'h0002);
    vdef(3, 10,  16'h0500, 8'h01, 0, -1, 0, 8'hFE, 8'h00, 8'h11, 8'h22, 16'h0501, 4, 0);
    vpre(3, 16'h0500, 8'hFE); vpre(3, 16'h00FF, 8'h11); vpre(3, 16'h0000, 8'h22);
    vrd(3, 16'h0500); vrd(3, 16'h00FF); vrd(3, 16'h0000);
    vdef(4,  2,  16'h0600, 8'h00, 3, -1, 0, 8'hA9, 8'h00, 8'h00, 8'h00, 16'h0601, 5, 0);
    vpre(4, 16'h0600, 8'hA9);
    vrd(4, 16'h0600);
    vdef(5,  3,  16'h0700, 8'h00, 0,  0, 1, 8'hA9, 8'h00, 8'h00, 8'h00, 16'h0701, 5, 1);
    vdef(6,  0,  16'h0800, 8'h00, 0, -1, 0, 8'hA9, 8'h00, 8'h00, 8'h00, 16'h0800, 1, 0);
    vdef(7,  6,  16'hFFFF, 8'h00, 0, -1, 0, 8'h78, 8'h56, 8'h00, 8'h00, 16'h0001, 3, 0);
    vpre(7, 16'hFFFF, 8'h78); vpre(7, 16'h0000, 8'h56);
    vrd(7, 16'hFFFF); vrd(7, 16'h0000);
    vdef(8, 11,  16'h0900, 8'h00, 0, -1, 0, 8'hFF, 8'h00, 8'h44, 8'h33, 16'h0901, 4, 0);
    vpre(8, 16'h0900, 8'hFF); vpre(8, 16'h00FF, 8'h44); vpre(8, 16'h0000, 8'h33);
    vrd(8, 16'h0900); vrd(8, 16'h00FF); vrd(8, 16'h0000);
    vdef(9, 15,  16'h0A00, 8'h00, 0, -1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h0A00, 1, 0);
    vdef(10, 12, 16'h0B00, 8'h00, 1, -1, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 16'h0B01, 3, 0);
    vpre(10, 16'h0B00, 8'hF0);
    vrd(10, 16'h0B00);
    vdef(11, 9,  16'h0C00, 8'h00, 0,  2, 0, 8'h10, 8'h20, 8'h00, 8'h00, 16'h0C02, 7, 1);
    vpre(11, 16'h0C00, 8'h10); vpre(11, 16'h0C01, 8'h20);
    vrd(11, 16'h0C00); vrd(11, 16'h0C01);
    vdef(12, 6,  16'h0D00, 8'h00, 3, -1, 0, 8'h9A, 8'hBC, 8'h00, 8'h00, 16'h0D02, 9, 0);
    vpre(12, 16'h0D00, 8'h9A); vpre(12, 16'h0D01, 8'hBC);
    vrd(12, 16'h0D00); vrd(12, 16'h0D01);
    vdef(13, 13, 16'h0E00, 8'h00, 0, -1, 0, 8'h9A, 8'h00, 8'h00, 8'h00, 16'h0E00, 1, 0);

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("vec%0d", i);
      for (int j = 0; j < vt[i].npre; j++) mem[vt[i].pa[j]] = vt[i].pd[j];
      e_n = vt[i].nrd;
      for (int j = 0; j < vt[i].nrd; j++) e_addr[j] = vt[i].ea[j];
      e_lo = vt[i].lo; e_hi = vt[i].hi; e_ilo = vt[i].ilo; e_ihi = vt[i].ihi;
      e_pcn = vt[i].pcn; e_done = vt[i].dcyc; e_berr = vt[i].berr;
      run_fetch(vt[i].mode, vt[i].pc, vt[i].x, vt[i].waits, vt[i].stuck, vt[i].poke, tag);
      compare(tag);
    end

    // Asynchronous reset during OP_HI of an absolute fetch
    mem[16'h0300] = 8'h34; mem[16'h0301] = 8'h12;
    start = 1'b1; mode = 4'd6; pc_in = 16'h0300; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_seq op_lo_addr", mem_addr, 16'h0300);
    mem_ready = 1'b1; mem_rdata = 8'h34;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rst_seq op_hi_addr", mem_addr, 16'h0301);
    check("rst_seq op_lo_captured", operand_lo, 8'h34);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_seq async");
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("rst_seq no_done", done, 1'b0);
      check("rst_seq idle", busy, 1'b0);
    end
    mdl_lo = 8'h00; mdl_hi = 8'h00; mdl_ilo = 8'h00; mdl_ihi = 8'h00;

    // Randomized fetches against the reference model
    for (int r = 0; r < 40; r++) begin
      rm = 4'($urandom_range(0, 15));
      rw = $urandom_range(0, 3);
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      pc_in = 16'($urandom);
      x_reg = 8'($urandom);
      tag = $sformatf("rnd%0d_m%0d", r, rm);
      model(rm, pc_in, x_reg, rw, rs);
      run_fetch(rm, pc_in, x_reg, rw, rs, 1'b0, tag);
      compare(tag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
